// File: rtl/vlc_bitstream_packer.sv
// Packs right-aligned VLC codewords MSB-first into 32-bit big-endian words behind a small output FIFO.
// Optional VLC_PACKER_BITCOUNT_EN adds a bit_count port and a fill-bound assertion.
module vlc_bitstream_packer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LEN_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             input_valid,
    output logic             input_ready,
    input  logic [31:0]      sum,
    input  logic [LEN_W-1:0] codeword_length,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_word,
    output logic [2:0]       out_bytes,
    output logic             out_last,
    output logic             len_err
`ifdef VLC_PACKER_BITCOUNT_EN
    ,
    output logic [31:0]      bit_count
`endif
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned ACC_W  = 64;
    localparam int unsigned FILL_W = 6;
    localparam int unsigned SUM_W  = 7;
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;

    typedef struct packed {
        logic [WORD_W-1:0] word;
        logic [2:0]        bytes;
        logic              last;
    } entry_t;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [ACC_W-1:0]  acc, acc_nxt;
    logic [FILL_W-1:0] fill, fill_nxt;
    logic              len_err_nxt;

    entry_t            mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count, count_nxt, free_nxt;
    logic              push, pop, ready_nxt;
    entry_t            push_entry, head;

    logic              accept;
    logic              len_over;
    logic [FILL_W-1:0] len6;
    logic [WORD_W-1:0] mask, masked;
    logic [SUM_W-1:0]  total, sh;
    logic [ACC_W-1:0]  merged;

    // Codeword alignment: place the masked codeword directly below the bits already held in acc.
    always_comb begin
        accept   = input_valid && input_ready;
        len_over = codeword_length > LEN_W'(32);
        len6     = FILL_W'(codeword_length);
        mask     = (len6 == FILL_W'(32)) ? '1 : ((WORD_W'(1) << len6) - WORD_W'(1));
        masked   = sum & mask;
        total    = SUM_W'(fill) + SUM_W'(len6);
        sh       = SUM_W'(64) - SUM_W'(fill) - SUM_W'(len6);
        merged   = acc | ({32'b0, masked} << sh);
    end

    // Next-state, packing and FIFO bookkeeping.
    always_comb begin
        state_nxt   = state;
        acc_nxt     = acc;
        fill_nxt    = fill;
        len_err_nxt = len_err;
        push        = 1'b0;
        push_entry  = '0;
        pop         = out_valid && out_ready;

        if (accept) begin
            if (len_over) begin
                len_err_nxt = 1'b1;
            end else if (len6 != '0) begin
                if (total >= SUM_W'(32)) begin
                    push       = 1'b1;
                    push_entry = '{word: merged[63:32], bytes: 3'd4, last: 1'b0};
                    acc_nxt    = {merged[31:0], 32'b0};
                    fill_nxt   = FILL_W'(total - SUM_W'(32));
                end else begin
                    acc_nxt  = merged;
                    fill_nxt = FILL_W'(total);
                end
            end
        end

        case (state)
            ST_RUN: begin
                if (flush) state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                // Input is stalled in this state, so this push never collides with a codeword push.
                if (count != CNT_W'(FIFO_DEPTH)) begin
                    push       = 1'b1;
                    push_entry = '{word: acc[63:32],
                                   bytes: 3'((SUM_W'(fill) + SUM_W'(7)) >> 3),
                                   last: 1'b1};
                    acc_nxt    = '0;
                    fill_nxt   = '0;
                    state_nxt  = ST_RUN;
                end
            end
            default: state_nxt = ST_RUN;
        endcase

        count_nxt = CNT_W'(count + CNT_W'(push) - CNT_W'(pop));
        free_nxt  = CNT_W'(FIFO_DEPTH) - count_nxt;
        ready_nxt = (state_nxt == ST_RUN) && (free_nxt >= CNT_W'(2));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_RUN;
            acc         <= '0;
            fill        <= '0;
            len_err     <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            out_valid   <= 1'b0;
            input_ready <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
        end else begin
            state       <= state_nxt;
            acc         <= acc_nxt;
            fill        <= fill_nxt;
            len_err     <= len_err_nxt;
            count       <= count_nxt;
            out_valid   <= (count_nxt != '0);
            input_ready <= ready_nxt;
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    assign head      = mem[rd_ptr];
    assign out_word  = head.word;
    assign out_bytes = head.bytes;
    assign out_last  = head.last;

`ifdef VLC_PACKER_BITCOUNT_EN
    // Running count of accepted codeword bits; cleared once the slice's final word is pushed.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_count <= '0;
        end else if (state == ST_FLUSH && state_nxt == ST_RUN) begin
            bit_count <= '0;
        end else if (accept && !len_over) begin
            bit_count <= bit_count + 32'(len6);
        end
    end

    fill_bound: assert property (@(posedge clk) disable iff (reset) fill < FILL_W'(32));
`endif

endmodule

// File: tb/tb_vlc_bitstream_packer.sv
// Directed bench for vlc_bitstream_packer: codeword table plus backpressure, length-error and reset sequences.
module tb_vlc_bitstream_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        input_valid;
    logic        input_ready;
    logic [31:0] sum;
    logic [31:0] codeword_length;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [2:0]  out_bytes;
    logic        out_last;
    logic        len_err;

    always #5 clk = ~clk;

    vlc_bitstream_packer #(.FIFO_DEPTH(4), .LEN_W(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .input_valid     (input_valid),
        .input_ready     (input_ready),
        .sum             (sum),
        .codeword_length (codeword_length),
        .flush           (flush),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_word        (out_word),
        .out_bytes       (out_bytes),
        .out_last        (out_last),
        .len_err         (len_err)
    );

    typedef struct packed {
        logic [31:0] w;
        logic [2:0]  b;
        logic        l;
    } obs_t;

    typedef struct {
        logic [31:0] sum;
        logic [31:0] len;
        bit          flush;
        int          n_exp;
        obs_t        e0;
        obs_t        e1;
    } vec_t;

    int   n_vec = 0;
    int   n_err = 0;
    obs_t got[$];
    vec_t vecs[24];

    // Record every word the consumer actually takes.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) got.push_back('{w: out_word, b: out_bytes, l: out_last});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] s, input logic [31:0] l, input bit f, input int n,
                                input obs_t e0, input obs_t e1);
        vec_t v;
        v.sum = s; v.len = l; v.flush = f; v.n_exp = n; v.e0 = e0; v.e1 = e1;
        return v;
    endfunction

    function automatic obs_t ob(input logic [31:0] w, input logic [2:0] b, input logic l);
        return '{w: w, b: b, l: l};
    endfunction

    task automatic apply(input logic [31:0] s, input logic [31:0] l, input bit f);
        int waitc = 0;
        while (!input_ready && waitc < 100) begin
            @(posedge clk); #1;
            waitc++;
        end
        if (!input_ready) begin
            check("input_ready_timeout", 32'(input_ready), 32'd1);
        end else begin
            input_valid = 1'b1; sum = s; codeword_length = l; flush = f;
            @(posedge clk); #1;
            input_valid = 1'b0; sum = '0; codeword_length = '0; flush = 1'b0;
        end
    endtask

    task automatic expect_words(input string name, input obs_t exp_q[$]);
        int   waitc = 0;
        obs_t g;
        while (got.size() < exp_q.size() && waitc < 60) begin
            @(posedge clk);
            waitc++;
        end
        repeat (3) @(posedge clk);
        #1;
        check({name, "_count"}, 32'(got.size()), 32'(exp_q.size()));
        foreach (exp_q[k]) begin
            if (got.size() > 0) begin
                g = got.pop_front();
                check($sformatf("%s_w%0d_word", name, k), g.w, exp_q[k].w);
                check($sformatf("%s_w%0d_bytes", name, k), 32'(g.b), 32'(exp_q[k].b));
                check($sformatf("%s_w%0d_last", name, k), 32'(g.l), 32'(exp_q[k].l));
            end
        end
        got.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t q[$];
        obs_t z;
        z = '0;

        for (int i = 0; i < 7; i++) vecs[i] = mk(32'hF, 4, 0, 0, z, z);
        vecs[7]  = mk(32'hF,        4,  0, 1, ob(32'hFFFFFFFF, 4, 0), z);
        vecs[8]  = mk(32'h1,        1,  0, 0, z, z);
        vecs[9]  = mk(32'h7FFFFFFF, 31, 0, 1, ob(32'hFFFFFFFF, 4, 0), z);
        vecs[10] = mk(32'h0,        0,  1, 1, ob(32'h00000000, 0, 1), z);
        vecs[11] = mk(32'hFFFFFFFD, 3,  1, 1, ob(32'hA0000000, 1, 1), z);
        vecs[12] = mk(32'hFFFFFFFF, 0,  0, 0, z, z);
        vecs[13] = mk(32'hFFFFFFFF, 32, 0, 1, ob(32'hFFFFFFFF, 4, 0), z);
        vecs[14] = mk(32'hFFFFDEAD, 16, 1, 1, ob(32'hDEAD0000, 2, 1), z);
        vecs[15] = mk(32'h123,      12, 0, 0, z, z);
        vecs[16] = mk(32'hABCDE,    20, 0, 1, ob(32'h123ABCDE, 4, 0), z);
        vecs[17] = mk(32'h7F,       7,  1, 1, ob(32'hFE000000, 1, 1), z);
        vecs[18] = mk(32'hAAAAAAAA, 31, 0, 0, z, z);
        vecs[19] = mk(32'h1,        1,  0, 1, ob(32'h55555555, 4, 0), z);
        vecs[20] = mk(32'h81,       8,  0, 0, z, z);
        vecs[21] = mk(32'h3C,       5,  1, 1, ob(32'h81E00000, 2, 1), z);
        vecs[22] = mk(32'h0FFFFFFF, 28, 0, 0, z, z);
        vecs[23] = mk(32'hAB,       8,  1, 2, ob(32'hFFFFFFFA, 4, 0), ob(32'hB0000000, 1, 1));

        reset = 1'b1; input_valid = 1'b0; sum = '0; codeword_length = '0; flush = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_input_ready", 32'(input_ready), 32'd0);
        check("rst_out_valid",   32'(out_valid),   32'd0);
        check("rst_out_word",    out_word,         32'd0);
        check("rst_out_bytes",   32'(out_bytes),   32'd0);
        check("rst_out_last",    32'(out_last),    32'd0);
        check("rst_len_err",     32'(len_err),     32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_rst_input_ready", 32'(input_ready), 32'd1);

        foreach (vecs[i]) begin
            apply(vecs[i].sum, vecs[i].len, vecs[i].flush);
            q.delete();
            if (vecs[i].n_exp > 0) q.push_back(vecs[i].e0);
            if (vecs[i].n_exp > 1) q.push_back(vecs[i].e1);
            expect_words($sformatf("vec%0d", i), q);
        end

        // Over-length codeword is dropped and the error flag sticks.
        apply(32'h12345678, 33, 0);
        q.delete();
        expect_words("len33", q);
        check("len_err_set", 32'(len_err), 32'd1);
        apply(32'hC3, 8, 1);
        q.delete(); q.push_back(ob(32'hC3000000, 1, 1));
        expect_words("after_len33", q);
        check("len_err_sticky", 32'(len_err), 32'd1);

        // Backpressure: words stay at the head, input stalls near full, nothing lost on release.
        out_ready = 1'b0;
        apply(32'hABCDE, 20, 0);
        apply(32'h12345, 20, 0);
        repeat (3) @(posedge clk);
        #1;
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_hold_word", out_word, 32'hABCDE123);
        check("bp_hold_bytes", 32'(out_bytes), 32'd4);
        apply(32'h11111111, 32, 0);
        apply(32'h22222222, 32, 0);
        check("bp_ready_drop", 32'(input_ready), 32'd0);
        check("bp_still_head", out_word, 32'hABCDE123);
        check("bp_nothing_taken", 32'(got.size()), 32'd0);
        out_ready = 1'b1;
        q.delete();
        q.push_back(ob(32'hABCDE123, 4, 0));
        q.push_back(ob(32'h45111111, 4, 0));
        q.push_back(ob(32'h11222222, 4, 0));
        expect_words("bp_release", q);
        apply(32'h0, 0, 1);
        q.delete(); q.push_back(ob(32'h22000000, 1, 1));
        expect_words("bp_flush", q);

        // Reset right after a flush: the pending tail word must never appear.
        apply(32'h81, 8, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_out_valid",   32'(out_valid),   32'd0);
        check("mid_rst_out_word",    out_word,         32'd0);
        check("mid_rst_out_bytes",   32'(out_bytes),   32'd0);
        check("mid_rst_out_last",    32'(out_last),    32'd0);
        check("mid_rst_len_err",     32'(len_err),     32'd0);
        check("mid_rst_input_ready", 32'(input_ready), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_ready_back", 32'(input_ready), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        check("mid_rst_no_word", 32'(got.size()), 32'd0);
        check("mid_rst_idle_valid", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
